// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: debounced push-button to one-cycle S/R pulses for sr_ff,
// with feedback verification and a sticky mismatch flag.
module sr_drive_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  input  logic             clr_in,
  input  logic             q_fb_in,
  output logic             s_out,
  output logic             r_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] press_cnt_out,
  output logic             err_out
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ?
                        $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    VERIFY
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync_q;
  logic             btn_sync;
  logic             btn_db;
  logic [DB_W-1:0]  db_cnt;
  logic             press_evt;
  logic             tgt, tgt_nxt;
  logic             s_nxt, r_nxt, busy_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign btn_sync = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_in};
    end
  end

  // Any reversion of btn_sync restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_sync == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_MAX) begin
      btn_db <= btn_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign press_evt = btn_sync & ~btn_db & (db_cnt == DB_MAX);

  always_comb begin
    state_nxt = state;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    busy_nxt  = 1'b0;
    tgt_nxt   = tgt;
    err_nxt   = err_out;
    cnt_nxt   = press_cnt_out;
    unique case (state)
      IDLE: begin
        if (clr_in) begin
          state_nxt = DRIVE;
          busy_nxt  = 1'b1;
          r_nxt     = 1'b1;
          tgt_nxt   = 1'b0;
          err_nxt   = 1'b0;
        end else if (press_evt) begin
          state_nxt = DRIVE;
          busy_nxt  = 1'b1;
          cnt_nxt   = press_cnt_out + CNT_W'(1);
          s_nxt     = ~q_fb_in;
          r_nxt     = q_fb_in;
          tgt_nxt   = ~q_fb_in;
        end
      end
      DRIVE: begin
        state_nxt = VERIFY;
        busy_nxt  = 1'b1;
      end
      VERIFY: begin
        state_nxt = IDLE;
        if (q_fb_in != tgt) begin
          err_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      s_out         <= 1'b0;
      r_out         <= 1'b0;
      busy_out      <= 1'b0;
      tgt           <= 1'b0;
      err_out       <= 1'b0;
      press_cnt_out <= '0;
    end else begin
      state         <= state_nxt;
      s_out         <= s_nxt;
      r_out         <= r_nxt;
      busy_out      <= busy_nxt;
      tgt           <= tgt_nxt;
      err_out       <= err_nxt;
      press_cnt_out <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: scoreboard bench for sr_drive_ctrl driving
// behavioural sr_ff models; a second instance covers counter wrap.
module tb_sr_drive_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       clr = 1'b0;
  logic       force0 = 1'b0;
  logic       s1, r1, busy1, err1;
  logic [7:0] cnt1;
  logic       s2, r2, busy2, err2;
  logic [1:0] cnt2;
  logic       q1 = 1'b0;
  logic       q2 = 1'b0;
  logic       fb1;

  typedef struct packed {
    logic [1:0] sr;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  exp_t       sbq[$];
  exp_t       cur;
  int         ph = 0;
  bit         sb_on = 1'b0;
  int         checks = 0;
  int         errs = 0;
  logic       exp_q = 1'b0;
  logic       exp_err = 1'b0;
  logic [7:0] exp_cnt = '0;
  logic [1:0] exp_cnt2 = '0;

  always #5 clk = ~clk;

  assign fb1 = force0 ? 1'b0 : q1;

  sr_drive_ctrl u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn),
    .clr_in        (clr),
    .q_fb_in       (fb1),
    .s_out         (s1),
    .r_out         (r1),
    .busy_out      (busy1),
    .press_cnt_out (cnt1),
    .err_out       (err1)
  );

  sr_drive_ctrl #(.CNT_W(2)) u_dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn),
    .clr_in        (clr),
    .q_fb_in       (q2),
    .s_out         (s2),
    .r_out         (r2),
    .busy_out      (busy2),
    .press_cnt_out (cnt2),
    .err_out       (err2)
  );

  // Behavioural sr_ff stand-ins (no reset, power up cleared).
  always @(posedge clk) begin
    if (s1) q1 <= 1'b1;
    else if (r1) q1 <= 1'b0;
    if (s2) q2 <= 1'b1;
    else if (r2) q2 <= 1'b0;
  end

  a_no_sr: assert property (@(posedge clk) !(s1 && r1) && !(s2 && r2));

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_press();
    logic fb_seen, tgt, fb_after;
    exp_t e;
    fb_seen  = force0 ? 1'b0 : exp_q;
    tgt      = ~fb_seen;
    exp_q    = tgt;
    fb_after = force0 ? 1'b0 : exp_q;
    exp_err  = exp_err | (fb_after != tgt);
    exp_cnt  = exp_cnt + 8'd1;
    exp_cnt2 = exp_cnt2 + 2'd1;
    e.sr     = tgt ? 2'b10 : 2'b01;
    e.cnt    = exp_cnt;
    e.err    = exp_err;
    sbq.push_back(e);
  endtask

  task automatic push_clear();
    exp_t e;
    exp_q   = 1'b0;
    exp_err = 1'b0;
    e.sr    = 2'b01;
    e.cnt   = exp_cnt;
    e.err   = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic wait_pulse(input string tag);
    int n;
    n = 0;
    while (n < 12 && !(s1 | r1)) begin
      step(1);
      n++;
    end
    chk(tag, n, 6);
  endtask

  task automatic press();
    btn = 1'b1;
    push_press();
    wait_pulse("latency");
    step(4);
    btn = 1'b0;
    step(10);
  endtask

  always @(negedge clk) begin
    if (!rst_n || !sb_on) begin
      ph = 0;
    end else begin
      chk("inv1", {31'd0, s1 & r1}, 0);
      chk("inv2", {31'd0, s2 & r2}, 0);
      case (ph)
        0: begin
          if (s1 | r1) begin
            if (sbq.size() == 0) begin
              chk("spurious", {30'd0, s1, r1}, 0);
              cur = '0;
            end else begin
              cur = sbq.pop_front();
              chk("kind", {30'd0, s1, r1}, {30'd0, cur.sr});
              chk("cnt", {24'd0, cnt1}, {24'd0, cur.cnt});
            end
            chk("busy_drv", {31'd0, busy1}, 1);
            ph = 1;
          end else begin
            chk("busy_idle", {31'd0, busy1}, 0);
          end
        end
        1: begin
          chk("pulse_w", {30'd0, s1, r1}, 0);
          chk("busy_ver", {31'd0, busy1}, 1);
          ph = 2;
        end
        default: begin
          chk("busy_end", {31'd0, busy1}, 0);
          chk("err", {31'd0, err1}, {31'd0, cur.err});
          ph = 0;
        end
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset with button and clear active.
    btn = 1'b1;
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_outs", {28'd0, s1, r1, busy1, err1}, 0);
      chk("rst_cnt", {24'd0, cnt1}, 0);
    end
    step(1);
    btn   = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b1;
    step(8);
    chk("post_rst", {26'd0, s1, r1, busy1, err1, cnt1 != 0, cnt2 != 0}, 0);
    sb_on = 1'b1;

    // Clean presses toggle the real flip-flop.
    press();
    chk("q_set", {31'd0, q1}, 1);
    chk("err_clean", {31'd0, err1}, 0);
    press();
    chk("q_rst", {31'd0, q1}, 0);
    chk("cnt_two", {24'd0, cnt1}, 2);

    // Bounce never reaches the threshold.
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      step(2);
    end
    btn = 1'b0;
    step(8);
    chk("bounce_cnt", {24'd0, cnt1}, {24'd0, exp_cnt});
    press();

    // Clear coincident with a press event: clear wins.
    btn = 1'b1;
    step(5);
    clr = 1'b1;
    push_clear();
    step(1);
    clr = 1'b0;
    step(8);
    btn = 1'b0;
    step(10);
    chk("prio_cnt", {24'd0, cnt1}, {24'd0, exp_cnt});

    // Press event lands in DRIVE of a clear and is dropped.
    btn = 1'b1;
    step(4);
    clr = 1'b1;
    push_clear();
    step(1);
    clr = 1'b0;
    step(8);
    btn = 1'b0;
    step(10);
    chk("drop_cnt", {24'd0, cnt1}, {24'd0, exp_cnt});

    // Feedback stuck low: error sets and stays sticky.
    force0 = 1'b1;
    press();
    chk("err_set", {31'd0, err1}, 1);
    press();
    chk("err_sticky", {31'd0, err1}, 1);
    clr = 1'b1;
    push_clear();
    step(1);
    clr = 1'b0;
    step(6);
    chk("err_clr", {31'd0, err1}, 0);
    force0 = 1'b0;
    step(4);

    // Reset mid-command cuts the pulse; held button re-arms.
    sb_on = 1'b0;
    btn = 1'b1;
    n = 0;
    while (n < 12 && !(s1 | r1)) begin
      step(1);
      n++;
    end
    chk("mid_lat", n, 6);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_cut", {29'd0, s1, r1, busy1}, 0);
    step(2);
    sbq.delete();
    exp_cnt  = '0;
    exp_cnt2 = '0;
    exp_err  = 1'b0;
    sb_on    = 1'b1;
    rst_n    = 1'b1;
    push_press();
    wait_pulse("rearm_lat");
    step(4);
    btn = 1'b0;
    step(10);
    chk("rearm_cnt", {24'd0, cnt1}, 1);

    // Four more presses: five since reset wraps a 2-bit counter to 1.
    for (int i = 0; i < 4; i++) press();
    chk("wrap_cnt2", {30'd0, cnt2}, {30'd0, exp_cnt2});
    chk("cnt1_five", {24'd0, cnt1}, 5);

    step(4);
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sr_drive_ctrl.md
# sr_drive_ctrl

Control stage directly upstream of `sr_ff`. It turns a noisy, asynchronous push-button into clean one-cycle set/reset pulses on the flip-flop's S and R inputs. Each accepted press toggles the stored bit, and `s_out`/`r_out` are never asserted together, so the forbidden S=R=1 condition cannot occur. The block reads the flip-flop's `q_out` back, checks each command took effect, and flags a sticky error if it did not.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required to accept a button level change; legal range ≥2.
- `CNT_W`, default 8: width of the accepted-press counter.

- `clk` input 1: single clock; all state changes on posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `btn_in` input 1: raw button, asynchronous to `clk`, may bounce.
- `clr_in` input 1: synchronous clean clear request, level-sampled.
- `q_fb_in` input 1: feedback from `sr_ff.q_out`.
- `s_out` input-to-`sr_ff` output 1: set pulse, registered.
- `r_out` output 1: reset pulse, registered.
- `busy_out` output 1: high while a command is in flight.
- `press_cnt_out` output CNT_W: count of accepted presses, wraps.
- `err_out` output 1: sticky feedback-mismatch flag.

## Operation
- **Reset:** `rst_n`=0 immediately forces the following, independent of `clk`:
  - State IDLE.
  - `s_out`=0, `r_out`=0, `busy_out`=0, `press_cnt_out`=0, `err_out`=0.
  - Synchronizer flops, debounced level `btn_db` and debounce counter all 0.
- **Synchronizer:** 2-flop chain on `btn_in` produces `btn_sync`.
- **Debounce:** the counter clears whenever `btn_sync`==`btn_db`. Otherwise it increments. When it equals DEBOUNCE_CYCLES-1 and `btn_sync`!=`btn_db`, then at that edge:
  - `btn_db` takes `btn_sync`.
  - The counter clears.
- **Press event:** the cycle in which `btn_db` is updated from 0 to 1. Falling updates generate no event.
- **FSM states:**
  - IDLE:
    - If `clr_in`=1: enter DRIVE with `r_out`=1, target=0, and `err_out` cleared at that edge. The press counter does not change.
    - Else, if a press event occurs: enter DRIVE and increment `press_cnt_out` (modulo 2^CNT_W).
      - If `q_fb_in`=0, drive `s_out`=1 with target=1.
      - If `q_fb_in`=1, drive `r_out`=1 with target=0.
    - Else: stay in IDLE.
  - DRIVE: exactly one cycle. Deassert `s_out`/`r_out` at the next edge and go to VERIFY.
  - VERIFY: exactly one cycle. If `q_fb_in`!=target, set `err_out`=1 at the closing edge. Return to IDLE.
- `busy_out`=1 in DRIVE and VERIFY, 0 in IDLE. It is registered together with the state.
- **Ignored inputs:** press events and `clr_in` seen while in DRIVE or VERIFY are dropped, not queued. They are not counted and `err_out` is not cleared.
- **Simultaneous events:** if `clr_in` and a press event coincide in IDLE, clear wins and the press is dropped uncounted.
- **Sticky error:** `err_out` stays 1 until reset or an accepted clear.
- **Invariant:** `s_out`&`r_out` is never 1 in any cycle.

## Timing
- `btn_in` rises before edge 1 and stays stable. Then:
  - `btn_sync`=1 after edge 2.
  - `s_out`/`r_out` rise after edge 2+DEBOUNCE_CYCLES (edge 6 for the default).
- Each command occupies 2 cycles: DRIVE, then VERIFY. Back-to-back accepted commands are therefore at least 2 cycles apart.
- `clr_in` sampled high in IDLE drives `r_out` high after the same edge; latency is 1 cycle.
- `sr_ff` captures the pulse at the edge closing DRIVE. `q_fb_in` is checked at the edge closing VERIFY.
- Bounce: any reversion of `btn_sync` before the threshold restarts the count, so there is no event.
- Reset asserted mid-command:
  - The pulse is cut asynchronously.
  - After release, the FSM resumes in IDLE and `btn_db`=0.
  - If the button is still held, that press is re-accepted after DEBOUNCE_CYCLES stable cycles.

## Test plan
- **Reset:** hold `rst_n`=0, drive `btn_in`=1 and `clr_in`=1. Require all outputs 0 throughout. Release `rst_n` with `btn_in`=0: outputs stay 0.
- **Clean press, `q_fb_in` tied to a real `sr_ff`, Q=0, default parameters:**
  - `s_out`=1 for exactly one cycle, 6 edges after the `btn_in` rise.
  - Q becomes 1, `press_cnt_out`=1, `busy_out` high for 2 cycles, `err_out`=0.
  - A second press gives a one-cycle `r_out`, Q=0 and `press_cnt_out`=2.
- **Bounce:** toggle `btn_in` every 2 cycles for 20 cycles, then return it to 0. Require no pulse and `press_cnt_out` unchanged. Then hold `btn_in` high for 10 cycles: exactly one pulse.
- **Clear and priority:** `clr_in`=1 in the same cycle as a press event gives `r_out` only, and `press_cnt_out` is unchanged. A press during `busy_out`=1 is dropped with no second pulse.
- **Error path:** hold `q_fb_in`=0 and accept a press. `s_out` pulses, then `err_out`=1 after VERIFY and stays 1 across later presses. A `clr_in` pulse gives `err_out`=0.
- **Wrap and invariant, CNT_W=2:** 5 accepted presses give `press_cnt_out`=1. An assertion checks `s_out`&`r_out`==0 in every cycle of every test.
